color_classifier: RTL and testbench

COLOR_CLASSIFIER -- requirements
Module: color_classifier

---
 rtl/color_classifier.sv | 207 ++++++++++++++++++++
 tb/tb_color_classifier.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_classifier.sv
// Colour classifier: streams a frame out of a synchronous pixel memory, sums
// the R/G/B channels of the pixels inside a latched region of interest and
// classifies the region by its dominant channel.
module color_classifier #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int CH_W   = 4,
  parameter int ADDR_W = 15,
  parameter int MARGIN = 0,
  localparam int NUM_PIX = IMG_W * IMG_H,
  localparam int XW      = $clog2(IMG_W),
  localparam int YW      = $clog2(IMG_H),
  localparam int CNT_W   = $clog2(NUM_PIX) + 1,
  localparam int SUM_W   = CH_W + $clog2(NUM_PIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic [3*CH_W-1:0] data,
  input  logic [XW-1:0]     roi_x0,
  input  logic [XW-1:0]     roi_x1,
  input  logic [YW-1:0]     roi_y0,
  input  logic [YW-1:0]     roi_y1,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        res,
  output logic [SUM_W-1:0]  sum_r,
  output logic [SUM_W-1:0]  sum_g,
  output logic [SUM_W-1:0]  sum_b,
  output logic [CNT_W-1:0]  pix_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    CLASSIFY
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
  localparam logic [SUM_W:0]    MARGIN_W  = (SUM_W + 1)'(MARGIN);

  state_e             state_q, state_d;
  logic               start_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [XW-1:0]      rx0_q, rx0_d, rx1_q, rx1_d;
  logic [YW-1:0]      ry0_q, ry0_d, ry1_q, ry1_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   sr_q, sr_d, sg_q, sg_d, sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2:0]         res_q, res_d;

  logic               start_edge;
  logic               in_roi;
  logic [2:0]         class_c;
  logic [SUM_W:0]     r_w, g_w, b_w;

  assign start_edge = start & ~start_q;
  assign in_roi     = (x_q >= rx0_q) && (x_q <= rx1_q) &&
                      (y_q >= ry0_q) && (y_q <= ry1_q);

  // Dominant-channel decision, one bit wider so sum+MARGIN cannot wrap
  always_comb begin
    r_w     = {1'b0, sr_q};
    g_w     = {1'b0, sg_q};
    b_w     = {1'b0, sb_q};
    class_c = 3'b111;
    if (cnt_q == '0) begin
      class_c = 3'b000;
    end else if ((r_w > g_w + MARGIN_W) && (r_w > b_w + MARGIN_W)) begin
      class_c = 3'b100;
    end else if ((g_w > r_w + MARGIN_W) && (g_w > b_w + MARGIN_W)) begin
      class_c = 3'b010;
    end else if ((b_w > r_w + MARGIN_W) && (b_w > g_w + MARGIN_W)) begin
      class_c = 3'b001;
    end
  end

  // Next-state, address walk and accumulation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    rx0_d   = rx0_q;
    rx1_d   = rx1_q;
    ry0_d   = ry0_q;
    ry1_d   = ry1_q;
    valid_d = 1'b0;
    sr_d    = sr_q;
    sg_d    = sg_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    res_d   = res_q;

    // The pixel issued on the previous edge arrives now; it is added in
    // whatever state we are in, so the stall input never delays it.
    if (valid_q) begin
      sr_d  = sr_q + SUM_W'(data[3*CH_W-1:2*CH_W]);
      sg_d  = sg_q + SUM_W'(data[2*CH_W-1:CH_W]);
      sb_d  = sb_q + SUM_W'(data[CH_W-1:0]);
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = FETCH;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
          sr_d    = '0;
          sg_d    = '0;
          sb_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          rx0_d   = roi_x0;
          rx1_d   = roi_x1;
          ry0_d   = roi_y0;
          ry1_d   = roi_y1;
        end
      end
      FETCH: begin
        if (en) begin
          valid_d = in_roi;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        state_d = CLASSIFY;
      end
      CLASSIFY: begin
        res_d   = class_c;
        done_d  = 1'b1;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      ry0_q   <= '0;
      ry1_q   <= '0;
      valid_q <= 1'b0;
      sr_q    <= '0;
      sg_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rx0_q   <= rx0_d;
      rx1_q   <= rx1_d;
      ry0_q   <= ry0_d;
      ry1_q   <= ry1_d;
      valid_q <= valid_d;
      sr_q    <= sr_d;
      sg_q    <= sg_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign addr    = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign res     = res_q;
  assign sum_r   = sr_q;
  assign sum_g   = sg_q;
  assign sum_b   = sb_q;
  assign pix_cnt = cnt_q;

endmodule

// File: tb/tb_color_classifier.sv
// Bench for color_classifier: a full-size instance (A) and an 8x4, MARGIN=10
// instance (B), each with its own synchronous pixel memory model.
module tb_color_classifier;

  localparam int AW = 160, AH = 120, NPA = AW * AH;
  localparam int BW = 8, BH = 4, NPB = BW * BH, BMARGIN = 10;

  typedef struct {
    int sr;
    int sg;
    int sb;
    int pc;
    int res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance A signals
  logic        start_a = 1'b0, en_a = 1'b1;
  logic [11:0] data_a;
  logic [7:0]  ax0 = '0, ax1 = '0;
  logic [6:0]  ay0 = '0, ay1 = '0;
  logic [14:0] addr_a;
  logic        busy_a, done_a;
  logic [2:0]  res_a;
  logic [18:0] sr_a, sg_a, sb_a;
  logic [15:0] pc_a;

  // Instance B signals
  logic        start_b = 1'b0, en_b = 1'b1;
  logic [11:0] data_b;
  logic [2:0]  bx0 = '0, bx1 = '0;
  logic [1:0]  by0 = '0, by1 = '0;
  logic [4:0]  addr_b;
  logic        busy_b, done_b;
  logic [2:0]  res_b;
  logic [8:0]  sr_b, sg_b, sb_b;
  logic [5:0]  pc_b;

  logic [11:0] mem_a [NPA];
  logic [11:0] mem_b [NPB];

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  color_classifier u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .en(en_a), .data(data_a),
    .roi_x0(ax0), .roi_x1(ax1), .roi_y0(ay0), .roi_y1(ay1),
    .addr(addr_a), .busy(busy_a), .done(done_a), .res(res_a),
    .sum_r(sr_a), .sum_g(sg_a), .sum_b(sb_a), .pix_cnt(pc_a)
  );

  color_classifier #(.IMG_W(BW), .IMG_H(BH), .CH_W(4), .ADDR_W(5), .MARGIN(BMARGIN)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .en(en_b), .data(data_b),
    .roi_x0(bx0), .roi_x1(bx1), .roi_y0(by0), .roi_y1(by1),
    .addr(addr_b), .busy(busy_b), .done(done_b), .res(res_b),
    .sum_r(sr_b), .sum_g(sg_b), .sum_b(sb_b), .pix_cnt(pc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_a <= mem_a[int'(addr_a)];
  always @(posedge clk) data_b <= mem_b[int'(addr_b)];

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic exp_t model(input bit use_b, input int x0, x1, y0, y1);
    exp_t e;
    int w, h, m;
    logic [11:0] pix;
    e = '{default: 0};
    w = use_b ? BW : AW;
    h = use_b ? BH : AH;
    m = use_b ? BMARGIN : 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
          pix = use_b ? mem_b[y * w + x] : mem_a[y * w + x];
          e.sr += int'(pix[11:8]);
          e.sg += int'(pix[7:4]);
          e.sb += int'(pix[3:0]);
          e.pc++;
        end
      end
    end
    if (e.pc == 0) e.res = 0;
    else if (e.sr > e.sg + m && e.sr > e.sb + m) e.res = 4;
    else if (e.sg > e.sr + m && e.sg > e.sb + m) e.res = 2;
    else if (e.sb > e.sr + m && e.sb > e.sg + m) e.res = 1;
    else e.res = 7;
    return e;
  endfunction

  // Pulse start on A, scramble ROI inputs after the start edge, count edges to done
  task automatic run_a(output int lat, output bit to);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ax0 = 8'($urandom); ax1 = 8'($urandom); ay0 = 7'($urandom); ay1 = 7'($urandom);
    lat = 0; to = 1'b0;
    while (done_a !== 1'b1 && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > NPA + 50) to = 1'b1;
    end
  endtask

  // Same for B, optionally toggling en and counting en=0 edges before the last issue
  task automatic run_b(input bit stall, output int lat, output int stalls, output bit to);
    int issued;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    bx0 = 3'($urandom); bx1 = 3'($urandom); by0 = 2'($urandom); by1 = 2'($urandom);
    lat = 0; to = 1'b0; issued = 0; stalls = 0;
    while (done_b !== 1'b1 && !to) begin
      en_b = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      if (issued < NPB) begin
        if (en_b) issued++;
        else stalls++;
      end
      #1;
      lat++;
      if (lat > NPB + 200) to = 1'b1;
    end
    en_b = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({busy_a, done_a, res_a} !== 5'b0) begin errors++; $display("FAIL reset_a_ctrl: got %b expected 00000", {busy_a, done_a, res_a}); end
    checks++; if ({sr_a, sg_a, sb_a, pc_a, addr_a} !== '0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", {sr_a, sg_a, sb_a, pc_a, addr_a}); end
    checks++; if ({busy_b, done_b, res_b} !== 5'b0) begin errors++; $display("FAIL reset_b_ctrl: got %b expected 00000", {busy_b, done_b, res_b}); end
    checks++; if ({sr_b, sg_b, sb_b, pc_b, addr_b} !== '0) begin errors++; $display("FAIL reset_b_data: got %h expected 0", {sr_b, sg_b, sb_b, pc_b, addr_b}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_red();
    exp_t e;
    int lat;
    bit to;
    for (int i = 0; i < NPA; i++) mem_a[i] = 12'hF00;
    ax0 = 8'd0; ax1 = 8'd159; ay0 = 7'd0; ay1 = 7'd119;
    sb_q.push_back(model(1'b0, 0, 159, 0, 119));
    run_a(lat, to);
    e = sb_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL red_timeout: got no done expected done"); end
    checks++; if (lat != NPA + 2) begin errors++; $display("FAIL red_latency: got %0d expected %0d", lat, NPA + 2); end
    checks++; if (sr_a !== 19'd288000 || sr_a !== e.sr) begin errors++; $display("FAIL red_sum_r: got %0d expected %0d", sr_a, e.sr); end
    checks++; if (sg_a !== e.sg || sb_a !== e.sb) begin errors++; $display("FAIL red_sum_gb: got %0d/%0d expected %0d/%0d", sg_a, sb_a, e.sg, e.sb); end
    checks++; if (pc_a !== e.pc) begin errors++; $display("FAIL red_pix_cnt: got %0d expected %0d", pc_a, e.pc); end
    checks++; if (res_a !== 3'(e.res)) begin errors++; $display("FAIL red_res: got %b expected %b", res_a, 3'(e.res)); end
    checks++; if (busy_a !== 1'b0 || addr_a !== '0) begin errors++; $display("FAIL red_idle: got busy=%b addr=%0d expected busy=0 addr=0", busy_a, addr_a); end
  endtask

  task automatic test_abort_reset();
    exp_t e;
    int lat;
    bit to;
    logic [3:0] v;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (100) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    checks++; if ({busy_a, done_a, res_a} !== 5'b0) begin errors++; $display("FAIL abort_ctrl: got %b expected 00000", {busy_a, done_a, res_a}); end
    checks++; if ({sr_a, sg_a, sb_a, pc_a, addr_a} !== '0) begin errors++; $display("FAIL abort_data: got %h expected 0", {sr_a, sg_a, sb_a, pc_a, addr_a}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // R equals G on every pixel, B smaller: a tie with MARGIN=0
    for (int i = 0; i < NPA; i++) begin
      v = 4'(2 + (i % 13));
      mem_a[i] = {v, v, 4'(i % 3)};
    end
    ax0 = 8'd10; ax1 = 8'd19; ay0 = 7'd5; ay1 = 7'd9;
    sb_q.push_back(model(1'b0, 10, 19, 5, 9));
    run_a(lat, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != NPA + 2) begin errors++; $display("FAIL tie_latency: got %0d expected %0d", lat, NPA + 2); end
    checks++; if (sr_a !== e.sr || sg_a !== e.sg || sb_a !== e.sb) begin errors++; $display("FAIL tie_sums: got %0d/%0d/%0d expected %0d/%0d/%0d", sr_a, sg_a, sb_a, e.sr, e.sg, e.sb); end
    checks++; if (pc_a !== 16'd50) begin errors++; $display("FAIL tie_pix_cnt: got %0d expected 50", pc_a); end
    checks++; if (res_a !== 3'b111) begin errors++; $display("FAIL tie_res: got %b expected 111", res_a); end
  endtask

  task automatic test_roi_stall();
    exp_t e;
    int lat, stalls;
    bit to;
    for (int i = 0; i < NPB; i++) mem_b[i] = {4'(i % 16), 4'((i * 5 + 3) % 16), 4'((i * 7 + 1) % 16)};
    bx0 = 3'd2; bx1 = 3'd5; by0 = 2'd1; by1 = 2'd2;
    sb_q.push_back(model(1'b1, 2, 5, 1, 2));
    run_b(1'b1, lat, stalls, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != NPB + 2 + stalls) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, NPB + 2 + stalls); end
    checks++; if (sr_b !== e.sr || sg_b !== e.sg || sb_b !== e.sb) begin errors++; $display("FAIL stall_sums: got %0d/%0d/%0d expected %0d/%0d/%0d", sr_b, sg_b, sb_b, e.sr, e.sg, e.sb); end
    checks++; if (pc_b !== 6'd8) begin errors++; $display("FAIL stall_pix_cnt: got %0d expected 8", pc_b); end
    checks++; if (res_b !== 3'(e.res)) begin errors++; $display("FAIL stall_res: got %b expected %b", res_b, 3'(e.res)); end
  endtask

  task automatic test_margin();
    logic [11:0] vals [6];
    exp_t e;
    int lat, stalls;
    bit to;
    vals = '{12'hC20, 12'hD20, 12'h2D0, 12'h00D, 12'h880, 12'h000};
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NPB; i++) mem_b[i] = vals[k];
      bx0 = 3'd3; bx1 = 3'd3; by0 = 2'd1; by1 = 2'd1;
      sb_q.push_back(model(1'b1, 3, 3, 1, 1));
      run_b(1'b0, lat, stalls, to);
      e = sb_q.pop_front();
      checks++; if (to || res_b !== 3'(e.res)) begin errors++; $display("FAIL margin_res[%0d]: got %b expected %b", k, res_b, 3'(e.res)); end
      checks++; if (sr_b !== e.sr || sg_b !== e.sg || sb_b !== e.sb || pc_b !== 6'd1) begin errors++; $display("FAIL margin_sums[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/1", k, sr_b, sg_b, sb_b, pc_b, e.sr, e.sg, e.sb); end
    end
  endtask

  task automatic test_inverted_roi();
    exp_t e;
    int lat, stalls;
    bit to;
    for (int i = 0; i < NPB; i++) mem_b[i] = 12'h9A5;
    bx0 = 3'd5; bx1 = 3'd2; by0 = 2'd0; by1 = 2'd3;
    sb_q.push_back(model(1'b1, 5, 2, 0, 3));
    run_b(1'b0, lat, stalls, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != NPB + 2) begin errors++; $display("FAIL inv_latency: got %0d expected %0d", lat, NPB + 2); end
    checks++; if (pc_b !== 6'(e.pc) || res_b !== 3'(e.res)) begin errors++; $display("FAIL inv_result: got cnt=%0d res=%b expected cnt=%0d res=%b", pc_b, res_b, e.pc, 3'(e.res)); end
    checks++; if ({sr_b, sg_b, sb_b} !== '0) begin errors++; $display("FAIL inv_sums: got %h expected 0", {sr_b, sg_b, sb_b}); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    for (int i = 0; i < NPB; i++) mem_b[i] = {4'((i * 3) % 16), 4'(i % 7), 4'((i + 9) % 16)};
    bx0 = 3'd0; bx1 = 3'd7; by0 = 2'd0; by1 = 2'd3;
    sb_q.push_back(model(1'b1, 0, 7, 0, 3));
    start_b = 1'b1;
    @(posedge clk); #1;
    bx0 = 3'd4; by1 = 2'd0;
    lat = 0;
    while (done_b !== 1'b1 && lat < NPB + 50) begin
      if (lat == 10) start_b = 1'b0;
      if (lat == 12) start_b = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    checks++; if (lat != NPB + 2) begin errors++; $display("FAIL held_latency: got %0d expected %0d", lat, NPB + 2); end
    checks++; if (sr_b !== e.sr || sg_b !== e.sg || sb_b !== e.sb || pc_b !== 6'(e.pc)) begin errors++; $display("FAIL held_sums: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", sr_b, sg_b, sb_b, pc_b, e.sr, e.sg, e.sb, e.pc); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL held_done_hold: got done=%b busy=%b expected done=1 busy=0", done_b, busy_b); end
    start_b = 1'b0;
    @(posedge clk); #1;
    bx0 = 3'd0; by1 = 2'd3;
    sb_q.push_back(model(1'b1, 0, 7, 0, 3));
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL restart_clear: got done=%b busy=%b expected done=0 busy=1", done_b, busy_b); end
    lat = 0;
    while (done_b !== 1'b1 && lat < NPB + 50) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    checks++; if (lat != NPB + 2 || pc_b !== 6'(e.pc) || sr_b !== e.sr) begin errors++; $display("FAIL restart_run: got lat=%0d cnt=%0d sr=%0d expected lat=%0d cnt=%0d sr=%0d", lat, pc_b, sr_b, NPB + 2, e.pc, e.sr); end
  endtask

  initial begin
    test_reset();
    test_full_red();
    test_abort_reset();
    test_roi_stall();
    test_margin();
    test_inverted_roi();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
